strip_candidate_scanner: RTL and testbench

STRIP_CANDIDATE_SCANNER -- requirements
Module: strip_candidate_scanner

---
 rtl/strip_candidate_scanner_if.sv | 30 +++
 rtl/strip_candidate_scanner.sv | 111 +++++++++++
 tb/tb_strip_candidate_scanner.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/strip_candidate_scanner_if.sv
// strip_candidate_scanner_if: request/candidate/commit bundle between the scanner and its selection stage
interface strip_candidate_scanner_if;
  logic       req_valid;
  logic [6:0] req_width;
  logic       req_ready;
  logic       cand_valid;
  logic [1:0] cand_count;
  logic [3:0] Id1;
  logic [3:0] Id2;
  logic [3:0] Id3;
  logic [6:0] Width1;
  logic [6:0] Width2;
  logic [6:0] Width3;
  logic       commit_valid;
  logic [3:0] commit_id;
  logic       commit_ok;
  logic       commit_err;
  logic       no_fit;
  logic       clear;
  modport slave (
    input  req_valid, req_width, commit_valid, commit_id, clear,
    output req_ready, cand_valid, cand_count, Id1, Id2, Id3, Width1, Width2, Width3,
           commit_ok, commit_err, no_fit
  );
  modport master (
    output req_valid, req_width, commit_valid, commit_id, clear,
    input  req_ready, cand_valid, cand_count, Id1, Id2, Id3, Width1, Width2, Width3,
           commit_ok, commit_err, no_fit
  );
endinterface

// File: rtl/strip_candidate_scanner.sv
// strip_candidate_scanner: finds the first three strips with room for an item and applies the chosen placement
module strip_candidate_scanner #(
  parameter int         NUM_STRIPS = 16,
  parameter logic [6:0] STRIP_CAP  = 7'd100
) (
  input logic                      clk,
  input logic                      rst_n,
  strip_candidate_scanner_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;
  localparam logic [3:0] LAST   = 4'(NUM_STRIPS - 1);
  logic [1:0] state;
  logic [6:0] rem [NUM_STRIPS];
  logic [6:0] wid;
  logic [3:0] idx;
  logic [3:0] cid;
  logic [1:0] cnt;
  logic [3:0] id [3];
  logic [6:0] w [3];
  logic       cv, ok, err, nf;
  logic       hit, done, match;
  logic [1:0] cnt_nx;
  // qualification of the strip under scan and whether the held choice names a filled slot
  always_comb begin
    hit    = rem[idx] >= wid;
    cnt_nx = cnt + 2'(hit);
    done   = (hit && cnt == 2'd2) || idx == LAST;
    match  = (cnt != 2'd0 && id[0] == cid) || (cnt >= 2'd2 && id[1] == cid) || (cnt == 2'd3 && id[2] == cid);
  end
  // control FSM, strip table and candidate slots
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      for (int s = 0; s < NUM_STRIPS; s++) rem[s] <= STRIP_CAP;
      wid <= '0;
      idx <= '0;
      cid <= '0;
      cnt <= '0;
      for (int s = 0; s < 3; s++) begin
        id[s] <= '0;
        w[s]  <= '0;
      end
      cv  <= 1'b0;
      ok  <= 1'b0;
      err <= 1'b0;
      nf  <= 1'b0;
    end else begin
      ok  <= 1'b0;
      err <= 1'b0;
      nf  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clear) for (int s = 0; s < NUM_STRIPS; s++) rem[s] <= STRIP_CAP;
          if (bus.req_valid) begin
            wid <= bus.req_width;
            idx <= '0;
            cnt <= '0;
            for (int s = 0; s < 3; s++) begin
              id[s] <= '0;
              w[s]  <= 7'h7F;
            end
            state <= SCAN;
          end
        end
        SCAN: begin
          for (int s = 0; s < 3; s++) begin
            if (hit && cnt == 2'(s)) begin
              id[s] <= idx;
              w[s]  <= rem[idx];
            end
          end
          cnt <= cnt_nx;
          idx <= idx + 4'd1;
          if (done) begin
            state <= cnt_nx == 2'd0 ? IDLE : HOLD;
            cv    <= cnt_nx != 2'd0;
            nf    <= cnt_nx == 2'd0;
          end
        end
        HOLD: begin
          if (bus.commit_valid) begin
            cid   <= bus.commit_id;
            state <= COMMIT;
          end
        end
        COMMIT: begin
          if (match) rem[cid] <= rem[cid] - wid;
          ok    <= match;
          err   <= !match;
          cv    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
  assign bus.req_ready  = state == IDLE;
  assign bus.cand_valid = cv;
  assign bus.cand_count = cnt;
  assign bus.Id1        = id[0];
  assign bus.Id2        = id[1];
  assign bus.Id3        = id[2];
  assign bus.Width1     = w[0];
  assign bus.Width2     = w[1];
  assign bus.Width3     = w[2];
  assign bus.commit_ok  = ok;
  assign bus.commit_err = err;
  assign bus.no_fit     = nf;
endmodule

// File: tb/tb_strip_candidate_scanner.sv
// tb_strip_candidate_scanner: random requests/commits against a table-level reference model
module tb_strip_candidate_scanner;
  localparam int NS  = 16;
  localparam int CAP = 100;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  strip_candidate_scanner_if bus();
  strip_candidate_scanner #(.NUM_STRIPS(NS), .STRIP_CAP(7'd100)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  int rem_m [NS];
  int exp_id [3];
  int exp_w [3];
  int ecnt, exp_lat, lw;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void model_scan(input int wd);
    int last = 0;
    ecnt = 0;
    for (int k = 0; k < 3; k++) begin
      exp_id[k] = 0;
      exp_w[k]  = 127;
    end
    for (int k = 0; k < NS; k++) begin
      if (ecnt < 3 && rem_m[k] >= wd) begin
        exp_id[ecnt] = k;
        exp_w[ecnt]  = rem_m[k];
        last = k;
        ecnt++;
      end
    end
    exp_lat = ecnt == 3 ? last + 2 : NS + 1;
  endfunction
  task automatic request(input int wd, input bit clr);
    int n;
    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_width = 7'(wd);
    bus.clear = clr;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.clear = 1'b0;
    if (clr) foreach (rem_m[k]) rem_m[k] = CAP;
    lw = wd;
    model_scan(wd);
    n = 1;
    @(negedge clk);
    while (!(bus.cand_valid || bus.no_fit) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, exp_lat);
    check("cand_valid", bus.cand_valid, ecnt != 0);
    check("no_fit", bus.no_fit, ecnt == 0);
    if (ecnt == 0) begin
      check("table_after_nofit", bus.req_ready, 1);
      @(negedge clk);
      check("no_fit_single", bus.no_fit, 0);
      check("cand_valid_nofit", bus.cand_valid, 0);
    end else begin
      check("cand_count", bus.cand_count, ecnt);
      check("Id1", bus.Id1, exp_id[0]);
      check("Id2", bus.Id2, exp_id[1]);
      check("Id3", bus.Id3, exp_id[2]);
      check("Width1", bus.Width1, exp_w[0]);
      check("Width2", bus.Width2, exp_w[1]);
      check("Width3", bus.Width3, exp_w[2]);
    end
  endtask
  task automatic commit(input int cid);
    bit m = 0;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("hold_valid", bus.cand_valid, 1);
      check("hold_Id1", bus.Id1, exp_id[0]);
    end
    for (int k = 0; k < ecnt; k++) if (exp_id[k] == cid) m = 1;
    bus.commit_valid = 1'b1;
    bus.commit_id = 4'(cid);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.commit_valid = 1'b0;
    @(negedge clk);
    check("commit_ok", bus.commit_ok, m);
    check("commit_err", bus.commit_err, !m);
    check("cand_valid_drop", bus.cand_valid, 0);
    check("ready_after_commit", bus.req_ready, 1);
    if (m) rem_m[cid] -= lw;
    @(negedge clk);
    check("commit_pulse_end", bus.commit_ok | bus.commit_err, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cand_valid", bus.cand_valid, 0);
    check("rst_cand_count", bus.cand_count, 0);
    check("rst_Id1", bus.Id1, 0);
    check("rst_Width1", bus.Width1, 0);
    check("rst_Width3", bus.Width3, 0);
    check("rst_pulses", {bus.commit_ok, bus.commit_err, bus.no_fit}, 0);
    rst_n = 1'b1;
    foreach (rem_m[k]) rem_m[k] = CAP;
    @(negedge clk);
    check("ready_after_rst", bus.req_ready, 1);
  endtask
  task automatic pulse_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    foreach (rem_m[k]) rem_m[k] = CAP;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int wd, r;
    bit clr;
    bus.req_valid = 1'b0;
    bus.req_width = '0;
    bus.commit_valid = 1'b0;
    bus.commit_id = '0;
    bus.clear = 1'b0;
    foreach (rem_m[k]) rem_m[k] = CAP;
    do_reset();
    request(30, 0);
    check("d_latency30", exp_lat, 4);
    check("d_Id3_30", bus.Id3, 2);
    check("d_Width1_30", bus.Width1, 100);
    commit(1);
    request(80, 0);
    check("d_Id2_80", bus.Id2, 2);
    check("d_Id3_80", bus.Id3, 3);
    commit(7);
    request(80, 0);
    check("d_Id2_again", bus.Id2, 2);
    commit(0);
    do_reset();
    for (int k = 0; k < NS; k++) begin
      request(60, 0);
      commit(exp_id[0]);
    end
    request(50, 0);
    check("d_nofit_lat", exp_lat, 17);
    request(0, 0);
    check("d_zero_count", bus.cand_count, 3);
    check("d_zero_Width1", bus.Width1, 40);
    commit(2);
    pulse_clear();
    request(30, 0);
    check("d_clear_Width3", bus.Width3, 100);
    commit(5);
    request(30, 0);
    do_reset();
    request(30, 0);
    commit(exp_id[2]);
    for (int it = 0; it < 90; it++) begin
      wd = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 60));
      clr = $urandom_range(0, 9) == 0;
      request(wd, clr);
      if (ecnt > 0) begin
        r = $urandom_range(0, 19);
        if (r == 0) do_reset();
        else if (r < 13) commit(exp_id[$urandom_range(0, ecnt - 1)]);
        else commit($urandom_range(0, 15));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
